regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
// - Shares the register file's single write port (we/regwriteaddr/regwritedata) between two writeback sources.
//   - Req 0 is the ALU writeback; req 1 is the load/memory writeback.
// - Registers the granted write into a one-deep write stage that drives the register file.
// - Forwards that in-flight write to the rs/rt read ports, so readers never see stale data.
// - Sits between the execute/memory stages and regFile.
// PARAMETERS
// - ADDR_W  5   register address width
// - DATA_W  32  register data width
// PORTS
// - clk           in   1       system clock; all state updates on rising edge
// - rst_n         in   1       asynchronous, active-low reset
// - wb_en         in   1       1 = grants allowed; 0 = freeze (no grants)
// - req0_valid    in   1       ALU write request
// - req0_addr     in   ADDR_W  ALU destination register
// - req0_data     in   DATA_W  ALU result
// - req0_ready    out  1       req0 accepted this cycle
// - req1_valid    in   1       load write request
// - req1_addr     in   ADDR_W  load destination register
// - req1_data     in   DATA_W  load data
// - req1_ready    out  1       req1 accepted this cycle
// - rf_we         out  1       register file write enable (registered)
// - rf_waddr      out  ADDR_W  register file write address (registered)
// - rf_wdata      out  DATA_W  register file write data (registered)
// - rsaddr        in   ADDR_W  rs read address (passed to regFile)
// - rtaddr        in   ADDR_W  rt read address (passed to regFile)
// - rsdata_rf     in   DATA_W  raw rs data from regFile
// - rtdata_rf     in   DATA_W  raw rt data from regFile
// - rsdata        out  DATA_W  forwarded rs data
// - rtdata        out  DATA_W  forwarded rt data
// BEHAVIOUR
// - Reset (async, rst_n=0):
//   - rf_we=0, rf_waddr=0, rf_wdata=0.
//   - Round-robin pointer ptr=0 (req0 has priority first).
//   - Reset mid-write discards the staged write.
// - Handshake: a request transfers in a cycle where valid && ready. readyX is combinational from valid, addr, ptr and wb_en.
// - Grant rules, evaluated in order:
//   1. wb_en=0: both ready=0.
//   2. Only one valid: that one is granted.
//   3. Both valid, same nonzero addr (collision): both ready=1; req1 data is staged, req0 is dropped. The load result wins. ptr is unchanged.
//   4. Both valid, different addr: grant req(ptr); ptr <= ~ptr after the grant. The loser holds valid/addr/data stable.
// - Any grant: ptr <= ~granted index (fairness). Exception: collision, per rule 3.
// - Write stage: on a grant, next cycle rf_we=1, rf_waddr=addr, rf_wdata=data.
//   - Granted addr==0: request accepted (ready=1) but rf_we=0 next cycle; $zero is never written.
//   - No grant: rf_we=0; waddr/wdata hold.
// - Latency: accept at edge N; rf_we high in cycle N+1; regFile commits at edge N+1.
//   - Throughput: 1 write per cycle.
// - Forwarding (combinational):
//   - rsdata = (rsaddr==0) ? 0 : (rf_we && rf_waddr==rsaddr) ? rf_wdata : rsdata_rf.
//   - rtdata uses the same rule on rtaddr.
// - Widths: no arithmetic; address compares are full ADDR_W width. ptr is 1 bit and wraps naturally.
// STRUCTURE
// - Shared package rf_pkg: ADDR_W, DATA_W, REG_ZERO=5'd0.
// - Sub-module rr_arbiter2 (two requesters, 1-bit pointer, grant/update outputs).
// - Top level holds the collision override, write stage register and forwarding muxes.
// TESTING
// - Reset: rst_n=0 with requests active -> rf_we=0, rf_waddr=0, rf_wdata=0; on release req0 is granted first.
// - Single request: req0 addr=3, data=8 -> req0_ready=1; next cycle rf_we=1, rf_waddr=3, rf_wdata=8.
// - Contention: both valid, req0 addr=4, req1 addr=5, held 4 cycles -> grants alternate 0,1,0,1; rf_waddr sequence 4,5,4,5.
// - Collision: req0 (7, 0x11) and req1 (7, 0x22) -> both ready=1; one write only: rf_waddr=7, rf_wdata=0x22.
// - $zero and freeze: req1 addr=0 -> ready=1, rf_we stays 0. wb_en=0 with valid=1 -> ready=0 until wb_en=1.
// - Forwarding: write addr=9, data=0xABCD staged, rsaddr=9, rsdata_rf=0 -> rsdata=0xABCD. rtaddr=0 -> rtdata=0.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared widths and constants for the register-file writeback path.
package rf_pkg;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter with a 1-bit priority pointer.
// The pointer moves away from whichever requester was just granted unless the caller holds it.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    input  logic       hold,
    output logic [1:0] gnt
);
    logic ptr_q, ptr_d;

    always_comb begin
        gnt   = 2'b00;
        ptr_d = ptr_q;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
        // Granting req0 hands priority to req1 next time, and vice versa.
        if ((|gnt) && !hold) ptr_d = gnt[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= 1'b0;
        else        ptr_q <= ptr_d;
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU and load writebacks onto the single register-file write port,
// stages the winner for one cycle, and forwards the staged write to rs/rt readers.
module regfile_wb_arbiter
    import rf_pkg::*;
#(
    parameter int ADDR_W = rf_pkg::ADDR_W,
    parameter int DATA_W = rf_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_en,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [ADDR_W-1:0] rsaddr,
    input  logic [ADDR_W-1:0] rtaddr,
    input  logic [DATA_W-1:0] rsdata_rf,
    input  logic [DATA_W-1:0] rtdata_rf,
    output logic [DATA_W-1:0] rsdata,
    output logic [DATA_W-1:0] rtdata
);
    localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);

    logic [1:0]        gnt;
    logic              collision;
    logic              granted;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

    // Same nonzero destination from both sides: the load is younger, so it wins
    // and the ALU result is simply retired without a write.
    assign collision = wb_en && req0_valid && req1_valid &&
                       (req0_addr == req1_addr) && (req0_addr != ZERO);

    rr_arbiter2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (wb_en),
        .req   ({req1_valid, req0_valid}),
        .hold  (collision),
        .gnt   (gnt)
    );

    assign req0_ready = collision || gnt[0];
    assign req1_ready = collision || gnt[1];
    assign granted    = collision || (|gnt);

    always_comb begin
        sel_addr   = req0_addr;
        sel_data   = req0_data;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (collision || gnt[1]) begin
            sel_addr = req1_addr;
            sel_data = req1_data;
        end
        // Writes to $zero are accepted but never reach the register file.
        if (granted && (sel_addr != ZERO)) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = sel_addr;
            rf_wdata_d = sel_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

    assign rsdata = (rsaddr == ZERO) ? '0 :
                    (rf_we_q && (rf_waddr_q == rsaddr)) ? rf_wdata_q : rsdata_rf;
    assign rtdata = (rtaddr == ZERO) ? '0 :
                    (rf_we_q && (rf_waddr_q == rtaddr)) ? rf_wdata_q : rtdata_rf;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, hand sequences for reset and
// forwarding, and random traffic against an architectural register-file model.
module tb_regfile_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_en = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [4:0]  req0_addr = '0, req1_addr = '0, rsaddr = '0, rtaddr = '0;
    logic [31:0] req0_data = '0, req1_data = '0, rsdata_rf = '0, rtdata_rf = '0;
    logic        req0_ready, req1_ready, rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, rsdata, rtdata;

    regfile_wb_arbiter dut (
        .clk(clk), .rst_n(rst_n), .wb_en(wb_en),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rsaddr(rsaddr), .rtaddr(rtaddr), .rsdata_rf(rsdata_rf), .rtdata_rf(rtdata_rf),
        .rsdata(rsdata), .rtdata(rtdata)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    // Reference state: committed file contents, newest architectural values,
    // the requester that currently has preference, and the expected staged write.
    logic [31:0] regs [32];
    logic [31:0] arch [32];
    int          pref;
    bit          m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    logic        obs_r0, obs_r1;

    typedef struct {
        bit en; bit v0; logic [4:0] a0; logic [31:0] d0;
        bit v1; logic [4:0] a1; logic [31:0] d1;
        bit r0; bit r1; bit we; logic [4:0] wa; logic [31:0] wd;
    } vec_t;
    vec_t tbl [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(bit en, bit v0, logic [4:0] a0, logic [31:0] d0,
                                bit v1, logic [4:0] a1, logic [31:0] d1,
                                bit r0, bit r1, bit we, logic [4:0] wa, logic [31:0] wd);
        vec_t v;
        v.en = en; v.v0 = v0; v.a0 = a0; v.d0 = d0; v.v1 = v1; v.a1 = a1; v.d1 = d1;
        v.r0 = r0; v.r1 = r1; v.we = we; v.wa = wa; v.wd = wd;
        return v;
    endfunction

    task automatic model_reset();
        m_we = 1'b0; m_waddr = '0; m_wdata = '0; pref = 0;
        for (int i = 0; i < 32; i++) arch[i] = regs[i];
    endtask

    // One clock: drive at edge+1, check handshake/forwarding mid-cycle, check stage at next edge+1.
    task automatic cyc(input bit en, input bit v0, input logic [4:0] a0, input logic [31:0] d0,
                       input bit v1, input logic [4:0] a1, input logic [31:0] d1,
                       input logic [4:0] rs, input logic [4:0] rt);
        bit e0, e1, acc;
        logic [4:0]  wa;
        logic [31:0] wd;
        wb_en = en; req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        rsaddr = rs; rtaddr = rt; rsdata_rf = regs[rs]; rtdata_rf = regs[rt];
        #2;
        e0 = 0; e1 = 0; acc = 0; wa = '0; wd = '0;
        if (en) begin
            if (v0 && v1 && a0 == a1 && a0 != 0) begin
                e0 = 1; e1 = 1; acc = 1; wa = a1; wd = d1;
            end else if (v0 && (!v1 || pref == 0)) begin
                e0 = 1; acc = 1; wa = a0; wd = d0; pref = 1;
            end else if (v1) begin
                e1 = 1; acc = 1; wa = a1; wd = d1; pref = 0;
            end
        end
        obs_r0 = req0_ready; obs_r1 = req1_ready;
        chk("req0_ready", 32'(req0_ready), 32'(e0));
        chk("req1_ready", 32'(req1_ready), 32'(e1));
        chk("rsdata", rsdata, (rs == 0) ? 32'd0 : arch[rs]);
        chk("rtdata", rtdata, (rt == 0) ? 32'd0 : arch[rt]);
        if (rf_we) regs[rf_waddr] = rf_wdata;
        m_we = acc && (wa != 0);
        if (m_we) begin
            m_waddr = wa; m_wdata = wd; arch[wa] = wd;
        end
        @(posedge clk); #1;
        chk("rf_we", 32'(rf_we), 32'(m_we));
        if (m_we) begin
            chk("rf_waddr", 32'(rf_waddr), 32'(m_waddr));
            chk("rf_wdata", rf_wdata, m_wdata);
        end
    endtask

    initial begin
        bit          v0, v1, en;
        logic [4:0]  a0, a1, rs, rt;
        logic [31:0] d0, d1;

        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        regs[0] = 32'hDEAD_BEEF;

        // Reset held with requests pending: nothing may be staged.
        wb_en = 1; req0_valid = 1; req0_addr = 5'd6; req0_data = 32'h66;
        req1_valid = 1; req1_addr = 5'd2; req1_data = 32'h22;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we", 32'(rf_we), 32'd0);
        chk("rst_waddr", 32'(rf_waddr), 32'd0);
        chk("rst_wdata", rf_wdata, 32'd0);
        rst_n = 1'b1;
        model_reset();

        tbl[0]  = mk(1, 1, 4, 32'h40, 1, 5, 32'h50,  1, 0, 1, 4, 32'h40);
        tbl[1]  = mk(1, 1, 4, 32'h40, 1, 5, 32'h50,  0, 1, 1, 5, 32'h50);
        tbl[2]  = mk(1, 1, 4, 32'h40, 1, 5, 32'h50,  1, 0, 1, 4, 32'h40);
        tbl[3]  = mk(1, 1, 4, 32'h40, 1, 5, 32'h50,  0, 1, 1, 5, 32'h50);
        tbl[4]  = mk(1, 1, 7, 32'h11, 1, 7, 32'h22,  1, 1, 1, 7, 32'h22);
        tbl[5]  = mk(1, 1, 1, 32'h01, 1, 2, 32'h02,  1, 0, 1, 1, 32'h01);
        tbl[6]  = mk(1, 1, 3, 32'h08, 0, 0, 32'h00,  1, 0, 1, 3, 32'h08);
        tbl[7]  = mk(1, 0, 0, 32'h00, 1, 0, 32'h99,  0, 1, 0, 0, 32'h00);
        tbl[8]  = mk(0, 1, 10, 32'hA0, 1, 11, 32'hB0, 0, 0, 0, 0, 32'h00);
        tbl[9]  = mk(0, 1, 10, 32'hA0, 1, 11, 32'hB0, 0, 0, 0, 0, 32'h00);
        tbl[10] = mk(1, 1, 10, 32'hA0, 1, 11, 32'hB0, 1, 0, 1, 10, 32'hA0);
        tbl[11] = mk(1, 0, 0, 32'h00, 0, 0, 32'h00,  0, 0, 0, 0, 32'h00);
        tbl[12] = mk(1, 1, 0, 32'h33, 1, 0, 32'h44,  0, 1, 0, 0, 32'h00);

        foreach (tbl[i]) begin
            cyc(tbl[i].en, tbl[i].v0, tbl[i].a0, tbl[i].d0, tbl[i].v1, tbl[i].a1, tbl[i].d1,
                5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            chk("tbl_r0", 32'(obs_r0), 32'(tbl[i].r0));
            chk("tbl_r1", 32'(obs_r1), 32'(tbl[i].r1));
            chk("tbl_we", 32'(rf_we), 32'(tbl[i].we));
            if (tbl[i].we) begin
                chk("tbl_waddr", 32'(rf_waddr), 32'(tbl[i].wa));
                chk("tbl_wdata", rf_wdata, tbl[i].wd);
            end
        end

        // Forwarding of the staged write while the file still holds stale data.
        cyc(1, 1, 9, 32'hABCD, 0, 0, 0, 0, 0);
        rsaddr = 9; rsdata_rf = 32'h0; rtaddr = 0; rtdata_rf = 32'h5555;
        #1;
        chk("fwd_rs", rsdata, 32'hABCD);
        chk("fwd_rt_zero", rtdata, 32'h0);
        rtaddr = 9; rtdata_rf = 32'h0;
        #1;
        chk("fwd_rt", rtdata, 32'hABCD);

        // Reset while a write is staged discards it and restores req0 priority.
        cyc(1, 1, 12, 32'hC0DE, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_we", 32'(rf_we), 32'd0);
        chk("midrst_waddr", 32'(rf_waddr), 32'd0);
        chk("midrst_wdata", rf_wdata, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        cyc(1, 1, 13, 32'h13, 1, 14, 32'h14, 12, 13);
        chk("postrst_first", 32'({obs_r1, obs_r0}), 32'b01);

        // Random traffic; unaccepted requests stay stable until taken.
        v0 = 0; v1 = 0; a0 = 0; a1 = 0; d0 = 0; d1 = 0;
        for (int n = 0; n < 400; n++) begin
            if (!v0 || obs_r0) begin
                v0 = ($urandom_range(0, 3) != 0); a0 = 5'($urandom_range(0, 7)); d0 = $urandom;
            end
            if (!v1 || obs_r1) begin
                v1 = ($urandom_range(0, 2) != 0); a1 = 5'($urandom_range(0, 7)); d1 = $urandom;
            end
            en = ($urandom_range(0, 99) < 88);
            rs = 5'($urandom_range(0, 8));
            rt = 5'($urandom_range(0, 8));
            cyc(en, v0, a0, d0, v1, a1, d1, rs, rt);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
